// File: rtl/clock_time_set_ctrl.sv
// Purpose: run/set controller for a six-digit BCD hh:mm:ss counter chain, with a mode/inc button editor.
// Latency: count_en is 1 clk after tick_1hz; button edges act 2 clks after the level rises.
// Backpressure: none; ticks and button edges are consumed or dropped in the cycle they arrive.
//
// Ports:
//   clock      system clock, all logic on posedge
//   reset_n    synchronous active-low reset
//   tick_1hz   one-cycle pulse per second
//   btn_mode   debounced mode button level
//   btn_inc    debounced increment button level
//   cur_time   live counter digits {Ht,Ho,Mt,Mo,St,So}
//   count_en   counter chain enable (1 = count, 0 = parallel load)
//   load_time  parallel-load value, same packing as cur_time
//   field_sel  0 none, 1 hours, 2 minutes, 3 seconds
module clock_time_set_ctrl #(
    parameter bit H24       = 1'b1,
    parameter int TIMEOUT_S = 30
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        tick_1hz,
    input  logic        btn_mode,
    input  logic        btn_inc,
    input  logic [23:0] cur_time,
    output logic        count_en,
    output logic [23:0] load_time,
    output logic [1:0]  field_sel
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        SET_H = 2'd1,
        SET_M = 2'd2,
        SET_S = 2'd3
    } state_t;

    localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_S);

    state_t      state;
    logic [23:0] edit;
    logic [7:0]  idle_cnt;
    logic        mode_q, mode_prev;
    logic        inc_q, inc_prev;
    logic        mode_p, inc_p;

    // Two-stage history: the edge appears one cycle after the level rises.
    // Both stages reset high so a button held through reset never fires.
    assign mode_p = mode_q & ~mode_prev;
    assign inc_p  = inc_q  & ~inc_prev;

    // Outside RUN the counters keep reloading the edit value, so leaving
    // SET (by button or timeout) resumes from the edited time.
    assign load_time = (state == RUN) ? cur_time : edit;
    assign field_sel = state;

    // Minutes/seconds: 00..59, anything invalid wraps to 00.
    function automatic logic [7:0] inc_ms(input logic [7:0] v);
        logic [7:0] r;
        if (v[7:4] > 4'd5 || v[3:0] > 4'd9 || v == 8'h59)
            r = 8'h00;
        else if (v[3:0] == 4'd9)
            r = {v[7:4] + 4'd1, 4'd0};
        else
            r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

    // Hours: 00..23 in 24 h mode, 01..12 in 12 h mode; invalid wraps to the minimum.
    function automatic logic [7:0] inc_hr(input logic [7:0] v);
        logic [7:0] r;
        logic       bad;
        if (H24) begin
            bad = v[7:4] > 4'd2 || v[3:0] > 4'd9 || (v[7:4] == 4'd2 && v[3:0] > 4'd3);
            if (bad || v == 8'h23)
                r = 8'h00;
            else if (v[3:0] == 4'd9)
                r = {v[7:4] + 4'd1, 4'd0};
            else
                r = {v[7:4], v[3:0] + 4'd1};
        end else begin
            bad = v[7:4] > 4'd1 || v[3:0] > 4'd9 || v == 8'h00 ||
                  (v[7:4] == 4'd1 && v[3:0] > 4'd2);
            if (bad || v == 8'h12)
                r = 8'h01;
            else if (v[3:0] == 4'd9)
                r = {v[7:4] + 4'd1, 4'd0};
            else
                r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state     <= RUN;
            count_en  <= 1'b0;
            edit      <= 24'h0;
            idle_cnt  <= 8'd0;
            mode_q    <= 1'b1;
            mode_prev <= 1'b1;
            inc_q     <= 1'b1;
            inc_prev  <= 1'b1;
        end else begin
            mode_q    <= btn_mode;
            mode_prev <= mode_q;
            inc_q     <= btn_inc;
            inc_prev  <= inc_q;

            // A mode edge in RUN swallows a coincident tick, so the time
            // captured into edit is exactly what stays frozen.
            count_en <= tick_1hz && (state == RUN) && !mode_p;

            case (state)
                RUN: begin
                    idle_cnt <= 8'd0;
                    if (mode_p) begin
                        state <= SET_H;
                        edit  <= cur_time;
                    end
                end
                default: begin
                    if (idle_cnt == TIMEOUT_LIM) begin
                        state    <= RUN;
                        idle_cnt <= 8'd0;
                    end else if (mode_p) begin
                        // Mode wins over a coincident inc edge.
                        idle_cnt <= 8'd0;
                        case (state)
                            SET_H:   state <= SET_M;
                            SET_M:   state <= SET_S;
                            default: state <= RUN;
                        endcase
                    end else if (inc_p) begin
                        idle_cnt <= 8'd0;
                        case (state)
                            SET_H:   edit[23:16] <= inc_hr(edit[23:16]);
                            SET_M:   edit[15:8]  <= inc_ms(edit[15:8]);
                            default: edit[7:0]   <= inc_ms(edit[7:0]);
                        endcase
                    end else if (tick_1hz && idle_cnt < TIMEOUT_LIM) begin
                        idle_cnt <= idle_cnt + 8'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clock_time_set_ctrl.sv
// Purpose: directed self-checking bench for clock_time_set_ctrl (24 h / 30 s and 12 h / 3 s instances).
// Latency: checks sampled on negedge, one full cycle after inputs change.
// Backpressure: n/a.
module tb_clock_time_set_ctrl;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        tick, btn_mode, btn_inc, use_b;
    logic [23:0] cur_a, cur_b;
    logic        en_a, en_b;
    logic [23:0] lt_a, lt_b;
    logic [1:0]  fs_a, fs_b;

    logic        sel_en;
    logic [23:0] sel_lt, sel_cur;
    logic [1:0]  sel_fs;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clock = ~clock;

    // Stimulus is steered to one instance at a time.
    clock_time_set_ctrl #(.H24(1'b1), .TIMEOUT_S(30)) u_dut_a (
        .clock     (clock),
        .reset_n   (reset_n),
        .tick_1hz  (tick & ~use_b),
        .btn_mode  (btn_mode & ~use_b),
        .btn_inc   (btn_inc & ~use_b),
        .cur_time  (cur_a),
        .count_en  (en_a),
        .load_time (lt_a),
        .field_sel (fs_a)
    );

    clock_time_set_ctrl #(.H24(1'b0), .TIMEOUT_S(3)) u_dut_b (
        .clock     (clock),
        .reset_n   (reset_n),
        .tick_1hz  (tick & use_b),
        .btn_mode  (btn_mode & use_b),
        .btn_inc   (btn_inc & use_b),
        .cur_time  (cur_b),
        .count_en  (en_b),
        .load_time (lt_b),
        .field_sel (fs_b)
    );

    assign sel_en  = use_b ? en_b  : en_a;
    assign sel_lt  = use_b ? lt_b  : lt_a;
    assign sel_fs  = use_b ? fs_b  : fs_a;
    assign sel_cur = use_b ? cur_b : cur_a;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Hold the buttons two cycles (edge acts), release two cycles.
    task automatic press(input logic m, input logic i);
        btn_mode = m;
        btn_inc  = i;
        repeat (2) @(negedge clock);
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    // One-cycle tick; count_en must be low while tick is high, then
    // show exp for exactly one cycle.
    task automatic tick_pulse(input string tag, input logic exp);
        tick = 1'b1;
        chk({tag, "_pre"}, sel_en, 1'b0);
        @(negedge clock);
        tick = 1'b0;
        chk(tag, sel_en, exp);
        @(negedge clock);
        chk({tag, "_off"}, sel_en, 1'b0);
        @(negedge clock);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, n_chk=%0d", n_chk);
        $fatal(1);
    end

    initial begin
        reset_n  = 1'b0;
        tick     = 1'b0;
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        use_b    = 1'b0;
        cur_a    = 24'h123456;
        cur_b    = 24'h120000;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        // Reset state and RUN passthrough.
        chk("rst_en", en_a, 1'b0);
        chk("rst_fs", fs_a, 2'd0);
        chk("rst_lt", lt_a, 24'h123456);

        // Three ticks, three single-cycle enables.
        tick_pulse("t1_tick1", 1'b1);
        chk("t1_lt1", lt_a, 24'h123456);
        tick_pulse("t1_tick2", 1'b1);
        tick_pulse("t1_tick3", 1'b1);
        chk("t1_lt3", lt_a, 24'h123456);

        // 23:59:10, edit hours: 23 -> 00.
        cur_a = 24'h235910;
        @(negedge clock);
        press(1'b1, 1'b0);
        chk("t2_fs_h", fs_a, 2'd1);
        chk("t2_lt_cap", lt_a, 24'h235910);
        press(1'b0, 1'b1);
        chk("t2_lt_inc", lt_a, 24'h005910);
        tick_pulse("t2_tick_set", 1'b0);

        // Minutes 59 -> 00 -> 01, seconds 10 -> 11, back to RUN.
        press(1'b1, 1'b0);
        chk("t3_fs_m", fs_a, 2'd2);
        press(1'b0, 1'b1);
        chk("t3_min_wrap", lt_a, 24'h000010);
        press(1'b0, 1'b1);
        chk("t3_min_01", lt_a, 24'h000110);
        press(1'b1, 1'b0);
        chk("t3_fs_s", fs_a, 2'd3);
        press(1'b0, 1'b1);
        chk("t3_sec_11", lt_a, 24'h000111);
        press(1'b1, 1'b0);
        chk("t3_fs_run", fs_a, 2'd0);
        cur_a = 24'h000111;
        @(negedge clock);
        chk("t3_lt_run", lt_a, 24'h000111);
        tick_pulse("t3_tick", 1'b1);

        // Simultaneous mode+inc in SET_H: mode wins, edit unchanged.
        press(1'b1, 1'b0);
        chk("t6_fs_h", fs_a, 2'd1);
        press(1'b1, 1'b1);
        chk("t6_fs_m", fs_a, 2'd2);
        chk("t6_lt_keep", lt_a, 24'h000111);
        press(1'b1, 1'b0);
        chk("t6_fs_s", fs_a, 2'd3);

        // Reset mid-edit: back to RUN, passthrough, no enable.
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        chk("t6_rst_fs", fs_a, 2'd0);
        chk("t6_rst_en", en_a, 1'b0);
        chk("t6_rst_lt", lt_a, 24'h000111);
        @(negedge clock);

        // 12 h instance: 12 -> 01, then 00 (invalid) -> 01.
        use_b = 1'b1;
        @(negedge clock);
        press(1'b1, 1'b0);
        chk("t4_fs_h", sel_fs, 2'd1);
        press(1'b0, 1'b1);
        chk("t4_12_to_01", sel_lt, 24'h010000);
        repeat (3) press(1'b1, 1'b0);
        chk("t4_fs_run", sel_fs, 2'd0);
        cur_b = 24'h003000;
        @(negedge clock);
        chk("t4_lt_run", sel_lt, sel_cur);
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        chk("t4_00_to_01", sel_lt, 24'h013000);

        // Timeout of 3 ticks in SET_M, then the next tick counts.
        press(1'b1, 1'b0);
        chk("t5_fs_m", sel_fs, 2'd2);
        tick_pulse("t5_tick1", 1'b0);
        tick_pulse("t5_tick2", 1'b0);
        chk("t5_fs_still_m", sel_fs, 2'd2);
        chk("t5_lt_edit", sel_lt, 24'h013000);
        tick_pulse("t5_tick3", 1'b0);
        chk("t5_fs_run", sel_fs, 2'd0);
        tick_pulse("t5_tick4", 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
